// File: rtl/ern_pkg.sv
// Shared types, limits, state encoding and the 17-to-16-bit clamp for the
// prediction-error front end of the ERN/FRN path.
package ern_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic signed [15:0] err_t;

    localparam int ERR_MAX = 32767;
    localparam int ERR_MIN = -32768;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } pe_state_e;

    // A 17-bit difference fits in 16 bits exactly when its top two bits agree.
    function automatic logic sat_clipped(input logic signed [16:0] x);
        return x[16] ^ x[15];
    endfunction

    function automatic err_t sat16(input logic signed [16:0] x);
        if (!sat_clipped(x)) begin
            return x[15:0];
        end else if (x[16]) begin
            return err_t'(ERR_MIN);
        end else begin
            return err_t'(ERR_MAX);
        end
    endfunction

endpackage

// File: rtl/pe_leaky_integrator.sv
// Leaky-integrator prediction register: direct load, or shift-add update
// toward the incoming sample by (sample - prediction) >>> ALPHA_SHIFT.
module pe_leaky_integrator
    import ern_pkg::*;
#(
    parameter int ALPHA_SHIFT = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               en_i,
    input  logic signed [15:0] sample_i,
    output logic signed [16:0] diff_o,
    output logic signed [15:0] pred_o
);

    sample_t            pred_q;
    sample_t            pred_d;
    logic signed [15:0] step;

    assign diff_o = 17'(sample_i) - 17'(pred_q);

    // The step never exceeds the distance to the sample, so the sum stays in
    // range and a 16-bit modular add of the truncated step is exact.
    always_comb begin
        step   = 16'(diff_o >>> ALPHA_SHIFT);
        pred_d = pred_q + step;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_q <= '0;
        end else if (load_i) begin
            pred_q <= sample_i;
        end else if (en_i) begin
            pred_q <= pred_d;
        end
    end

    assign pred_o = pred_q;

endmodule

// File: rtl/prediction_error_unit.sv
// Turns the raw observation stream into a saturated signed prediction error
// with a one-cycle strobe, after an initial warm-up of the prediction.
module prediction_error_unit
    import ern_pkg::*;
#(
    parameter int ALPHA_SHIFT = 3,
    parameter int WARMUP      = 8,
    parameter int MIN_GAP     = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [15:0] sample_in,
    input  logic               sample_valid,
    output logic               sample_ready,
    input  logic               freeze,
    output logic signed [15:0] error_raw,
    output logic               error_valid,
    output logic signed [15:0] prediction,
    output logic               warm,
    output logic [7:0]         sat_count
);

    pe_state_e          state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [3:0]         gap_q, gap_d;
    logic [7:0]         sat_q, sat_d;
    err_t               err_q;
    logic               evld_q;
    logic               xfer;
    logic               load;
    logic               upd;
    logic               emit;
    logic signed [16:0] diff;
    sample_t            pred;

    assign sample_ready = (gap_q == 4'd0);
    assign xfer         = sample_valid && sample_ready;

    pe_leaky_integrator #(
        .ALPHA_SHIFT(ALPHA_SHIFT)
    ) u_integrator (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load),
        .en_i    (upd),
        .sample_i(sample_in),
        .diff_o  (diff),
        .pred_o  (pred)
    );

    // The first sample seeds the prediction; freeze is ignored for it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        upd     = 1'b0;
        emit    = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (xfer) begin
                    load    = 1'b1;
                    cnt_d   = 8'd1;
                    state_d = (WARMUP == 1) ? ST_RUN : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                if (xfer && !freeze) begin
                    upd   = 1'b1;
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_d == 8'(WARMUP)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (xfer) begin
                    emit = 1'b1;
                    upd  = !freeze;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        gap_d = gap_q;
        if (xfer) begin
            gap_d = 4'(MIN_GAP);
        end else if (gap_q != 4'd0) begin
            gap_d = gap_q - 4'd1;
        end
    end

    always_comb begin
        sat_d = sat_q;
        if (emit && sat_clipped(diff) && (sat_q != 8'hFF)) begin
            sat_d = sat_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            gap_q   <= '0;
            sat_q   <= '0;
            err_q   <= '0;
            evld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            sat_q   <= sat_d;
            evld_q  <= emit;
            if (emit) begin
                err_q <= sat16(diff);
            end
        end
    end

    assign error_raw   = err_q;
    assign error_valid = evld_q;
    assign prediction  = pred;
    assign warm        = (state_q == ST_RUN);
    assign sat_count   = sat_q;

endmodule

// File: tb/tb_prediction_error_unit.sv
// Scoreboard bench: three parameterisations of prediction_error_unit driven by
// directed and random streams, checked against a cycle-level behavioural model.
module tb_prediction_error_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    logic signed [15:0] s  [3];
    logic               v  [3];
    logic               f  [3];
    logic               rd [3];
    logic signed [15:0] er [3];
    logic               ev [3];
    logic signed [15:0] pr [3];
    logic               wm [3];
    logic [7:0]         sc [3];

    int p_as [3] = '{3, 0, 3};
    int p_wu [3] = '{4, 1, 8};
    int p_mg [3] = '{0, 0, 2};

    prediction_error_unit #(.ALPHA_SHIFT(3), .WARMUP(4), .MIN_GAP(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .sample_in(s[0]), .sample_valid(v[0]),
        .sample_ready(rd[0]), .freeze(f[0]), .error_raw(er[0]), .error_valid(ev[0]),
        .prediction(pr[0]), .warm(wm[0]), .sat_count(sc[0]));

    prediction_error_unit #(.ALPHA_SHIFT(0), .WARMUP(1), .MIN_GAP(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .sample_in(s[1]), .sample_valid(v[1]),
        .sample_ready(rd[1]), .freeze(f[1]), .error_raw(er[1]), .error_valid(ev[1]),
        .prediction(pr[1]), .warm(wm[1]), .sat_count(sc[1]));

    prediction_error_unit #(.ALPHA_SHIFT(3), .WARMUP(8), .MIN_GAP(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .sample_in(s[2]), .sample_valid(v[2]),
        .sample_ready(rd[2]), .freeze(f[2]), .error_raw(er[2]), .error_valid(ev[2]),
        .prediction(pr[2]), .warm(wm[2]), .sat_count(sc[2]));

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: phase 0=INIT, 1=WARMUP, 2=RUN.
    int m_pred [3];
    int m_cnt  [3];
    int m_st   [3];
    int m_gap  [3];
    int m_sat  [3];
    int m_last [3];
    bit m_ev   [3];
    bit m_xfer [3];
    int q0 [$];
    int q1 [$];
    int q2 [$];

    function automatic void qpush(int id, int e);
        case (id)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic int qsize(int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int qpop(int id);
        case (id)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Floor division by 2^sh, rounding toward minus infinity.
    function automatic int fdiv(int a, int sh);
        int d;
        d = 1 << sh;
        if (a >= 0) return a / d;
        return -((-a + d - 1) / d);
    endfunction

    function automatic int clamp16(int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    task automatic chk(string name, int id, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, id, act, exp, $time);
    endtask

    task automatic mreset(int id);
        m_pred[id] = 0; m_cnt[id] = 0; m_st[id] = 0; m_gap[id] = 0;
        m_sat[id] = 0; m_last[id] = 0; m_ev[id] = 1'b0; m_xfer[id] = 1'b0;
        case (id)
            0:       q0.delete();
            1:       q1.delete();
            default: q2.delete();
        endcase
    endtask

    task automatic mstep(int id);
        int smp;
        int d;
        int e;
        bit x;
        smp = int'(s[id]);
        x = (v[id] === 1'b1) && (m_gap[id] == 0);
        m_xfer[id] = x;
        m_ev[id] = 1'b0;
        if (x) m_gap[id] = p_mg[id];
        else if (m_gap[id] > 0) m_gap[id]--;
        if (x) begin
            case (m_st[id])
                0: begin
                    m_pred[id] = smp;
                    m_cnt[id]  = 1;
                    m_st[id]   = (p_wu[id] == 1) ? 2 : 1;
                end
                1: begin
                    if (f[id] !== 1'b1) begin
                        m_pred[id] += fdiv(smp - m_pred[id], p_as[id]);
                        m_cnt[id]++;
                        if (m_cnt[id] == p_wu[id]) m_st[id] = 2;
                    end
                end
                default: begin
                    d = smp - m_pred[id];
                    e = clamp16(d);
                    if (e != d && m_sat[id] < 255) m_sat[id]++;
                    m_ev[id] = 1'b1;
                    m_last[id] = e;
                    qpush(id, e);
                    if (f[id] !== 1'b1) m_pred[id] += fdiv(d, p_as[id]);
                end
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) mreset(i);
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) for (int i = 0; i < 3; i++) mreset(i);
            else        for (int i = 0; i < 3; i++) mstep(i);
        end
    end

    // Monitor: compares every DUT output against the model on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("ready", i, int'(rd[i]), int'(m_gap[i] == 0));
                chk("pred", i, int'(pr[i]), m_pred[i]);
                chk("warm", i, int'(wm[i]), int'(m_st[i] == 2));
                chk("satcnt", i, int'(sc[i]), m_sat[i]);
                chk("evld", i, int'(ev[i]), int'(m_ev[i]));
                if (ev[i] === 1'b1) begin
                    if (qsize(i) == 0) chk("err_unexpected", i, int'(er[i]), 99999);
                    else chk("err", i, int'(er[i]), qpop(i));
                end else begin
                    chk("errhold", i, int'(er[i]), m_last[i]);
                end
            end
        end
    end

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send(int id, int val, bit frz);
        int n;
        n = 0;
        s[id] = 16'(val);
        f[id] = frz;
        v[id] = 1'b1;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (!m_xfer[id] && n < 20);
        if (!m_xfer[id]) begin
            n_total++;
            $display("FAIL send_timeout dut%0d: got no transfer, expected one within 20 cycles", id);
        end
        v[id] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            s[i] = '0; v[i] = 1'b0; f[i] = 1'b0;
        end
        @(posedge clk);
        #2;
        idle(3);
        rst_n = 1'b1;
        idle(5);
        chk("rst_ready", 0, int'(rd[0]), 1);
        chk("rst_err", 0, int'(er[0]), 0);
        chk("rst_sat", 0, int'(sc[0]), 0);

        fork
            begin
                repeat (4) send(0, 800, 1'b0);
                chk("a_warm4", 0, int'(wm[0]), 1);
                chk("a_noev4", 0, int'(ev[0]), 0);
                send(0, 1000, 1'b0);
                chk("a_err200", 0, int'(er[0]), 200);
                chk("a_ev5", 0, int'(ev[0]), 1);
                chk("a_pred825", 0, int'(pr[0]), 825);
                idle(1);
                chk("a_ev_drop", 0, int'(ev[0]), 0);
                send(0, 1000, 1'b1);
                chk("a_err175", 0, int'(er[0]), 175);
                chk("a_frz_pred", 0, int'(pr[0]), 825);
            end
            begin
                send(1, 30000, 1'b0);
                send(1, -30000, 1'b0);
                chk("b_err_min", 1, int'(er[1]), -32768);
                chk("b_sat1", 1, int'(sc[1]), 1);
                chk("b_pred", 1, int'(pr[1]), -30000);
                send(1, 30000, 1'b0);
                chk("b_err_max", 1, int'(er[1]), 32767);
                chk("b_sat2", 1, int'(sc[1]), 2);
            end
            begin
                send(2, 100, 1'b0);
                repeat (3) send(2, 500, 1'b1);
                chk("c_frz_warm", 2, int'(wm[2]), 0);
                chk("c_frz_pred", 2, int'(pr[2]), 100);
                for (int k = 0; k < 10; k++) send(2, 200 + 40 * k, 1'b0);
            end
        join

        fork
            begin
                for (int k = 0; k < 14; k++) send(2, -300 + 50 * k, k[0]);
            end
            begin
                idle(12);
                rst_n = 1'b0;
                #1;
                chk("c_rst_warm", 2, int'(wm[2]), 0);
                chk("c_rst_ev", 2, int'(ev[2]), 0);
                chk("c_rst_pred", 2, int'(pr[2]), 0);
                #1;
                idle(1);
                chk("c_rst_ev_next", 2, int'(ev[2]), 0);
                rst_n = 1'b1;
            end
        join

        repeat (4) send(0, 0, 1'b0);
        send(0, -1, 1'b0);
        chk("a_err_m1", 0, int'(er[0]), -1);
        chk("a_pred_m1", 0, int'(pr[0]), -1);

        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                v[i] = ($urandom_range(0, 2) != 0);
                f[i] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 3) == 0) s[i] = 16'($urandom);
                else s[i] = 16'(int'($urandom_range(0, 600)) - 300);
            end
            if (c == 200) rst_n = 1'b0;
            if (c == 202) rst_n = 1'b1;
            idle(1);
        end

        for (int i = 0; i < 3; i++) v[i] = 1'b0;
        idle(5);
        for (int i = 0; i < 3; i++) chk("queue_empty", i, qsize(i), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
